// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array datapath blocks.
package systolic_pkg;

  localparam int SYS_N = 8;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } feeder_state_t;

  // Buffer row that feeds lane j at wavefront step t; in range only when 0 <= result < N.
  function automatic int skew_bit(input int t, input int j);
    return t - j;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Row-input and wavefront-output handshake bundle of the skew feeder.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int N = SYS_N
);

  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers N matrix rows, then emits them as a diagonally skewed wavefront
// (lane j delayed by j cycles) for the first row of systolic cells.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N = SYS_N
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int RC_W = $clog2(N);
  localparam int T_W  = $clog2(2 * N - 1);

  feeder_state_t   state_q, state_d;
  logic [RC_W-1:0] row_cnt_q, row_cnt_d;
  logic [T_W-1:0]  t_q, t_d;
  logic            wr_en;
  logic            t_last;
  logic [N-1:0]    row_buf [N];
  logic [N-1:0]    skew_word;

  assign t_last = (t_q == T_W'(2 * N - 2));

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    t_d       = t_q;
    wr_en     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (row_cnt_q == RC_W'(N - 1)) begin
            state_d   = EMIT;
            row_cnt_d = '0;
            t_d       = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (t_last) begin
            state_d   = LOAD;
            t_d       = '0;
            row_cnt_d = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
      t_q       <= '0;
      row_buf   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      t_q       <= t_d;
      if (wr_en) begin
        row_buf[row_cnt_q] <= bus.in_data;
      end
    end
  end

  // Loops run over constant (row, lane) pairs so every buffer select is static.
  always_comb begin
    skew_word = '0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (skew_bit(int'(t_q), int'(j)) == int'(r)) begin
          skew_word[j] = row_buf[r][j];
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD) && !rst;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_last  = (state_q == EMIT) && t_last;
  assign bus.out_data  = (state_q == EMIT) ? skew_word : '0;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (N = 8).
module tb_systolic_skew_feeder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  systolic_skew_feeder_if #(.N(8)) bus ();

  systolic_skew_feeder #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ones_rows [8];
  logic [7:0] id_rows   [8];
  logic [7:0] lo_rows   [8];
  logic [7:0] hi_rows   [8];
  logic [7:0] ones_exp  [15];
  logic [7:0] id_exp    [15];
  logic [7:0] lo_exp    [15];

  task automatic load_frame(input logic [7:0] rows [8], input int count, input string name);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s load_ready row %0d: in_ready=%b, required 1", name, i, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = rows[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic check_emit(input logic [7:0] exp [15], input string name, input int stall_at,
                            input int stall_len, input bit gate, input int stop_at);
    for (int k = 0; k < 15; k++) begin
      if (k == stop_at) return;
      if (gate) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s gate step %0d: in_ready=%b, required 0", name, k, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k] || bus.out_last !== (k == 14)) begin
        errors++;
        $display("FAIL %s step %0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 name, k, bus.out_valid, bus.out_data, bus.out_last, exp[k], (k == 14));
      end
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k] || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s stall %0d: valid=%b data=%h last=%b, required valid=1 data=%h last=0",
                     name, s, bus.out_valid, bus.out_data, bus.out_last, exp[k]);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL %s back_to_load: in_ready=%b out_valid=%b out_data=%h, required 1 0 00",
               name, bus.in_ready, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b valid=%b data=%h last=%b, required 0 0 00 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_last);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_all_ones();
    load_frame(ones_rows, 8, "all_ones");
    check_emit(ones_exp, "all_ones", -1, 0, 1'b0, 15);
  endtask

  task automatic test_identity();
    load_frame(id_rows, 8, "identity");
    check_emit(id_exp, "identity", -1, 0, 1'b0, 15);
  endtask

  task automatic test_back_pressure();
    load_frame(ones_rows, 8, "back_pressure");
    check_emit(ones_exp, "back_pressure", 3, 4, 1'b0, 15);
  endtask

  task automatic test_input_gating();
    load_frame(ones_rows, 8, "gating");
    check_emit(ones_exp, "gating", -1, 0, 1'b1, 15);
    load_frame(id_rows, 8, "gating_next");
    check_emit(id_exp, "gating_next", -1, 0, 1'b0, 15);
  endtask

  task automatic test_reset_mid_emit();
    load_frame(ones_rows, 8, "rst_emit");
    check_emit(ones_exp, "rst_emit", -1, 0, 1'b0, 5);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3F) begin
      errors++;
      $display("FAIL rst_emit pre_reset: valid=%b data=%h, required 1 3f", bus.out_valid, bus.out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit async: valid=%b data=%h last=%b in_ready=%b, required 0 00 0 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit release: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    load_frame(id_rows, 8, "rst_emit_id");
    check_emit(id_exp, "rst_emit_id", -1, 0, 1'b0, 15);
  endtask

  task automatic test_reset_mid_load();
    load_frame(hi_rows, 3, "rst_load_partial");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_frame(lo_rows, 8, "rst_load");
    check_emit(lo_exp, "rst_load", -1, 0, 1'b0, 15);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ones_rows[i] = 8'hFF;
      id_rows[i]   = 8'h01 << i;
      lo_rows[i]   = 8'h0F;
      hi_rows[i]   = 8'hF0;
    end
    ones_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    id_exp   = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00,
                 8'h10, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h80};
    lo_exp   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
                 8'h0E, 8'h0C, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};

    test_reset();
    test_all_ones();
    test_identity();
    test_back_pressure();
    test_input_gating();
    test_reset_mid_emit();
    test_reset_mid_load();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Input stage for the 8x8 systolic shift array. It accepts one matrix row per handshake on the dedicated inputs and buffers N rows. It then emits the buffered matrix as a diagonally skewed wavefront, one N-bit word per cycle: lane j is delayed by j cycles, so data enters the array's columns in systolic order. It sits between the top-level `ui_in` pins and the first row of systolic cells.

## Interface
- `N`, default 8: matrix dimension. It sets the row width, the number of rows buffered and the output lane count. Legal for N >= 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high. The top level drives it from inverted `rst_n`.
- `in_data`  in  N  one matrix row; bit j is column j.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  feeder can accept a row; it is high only in LOAD and low while `rst` is high.
- `out_data`  out  N  skewed wavefront word; lane j feeds array column j.
- `out_valid`  out  1  `out_data` is a valid wavefront step.
- `out_ready`  in  1  consumer accepts the word. The top level ties it high, so the array free-runs.
- `out_last`  out  1  marks the final wavefront step (t = 2N-2).

## Operation
- **State machine**: two states, LOAD and EMIT.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid && in_ready` cycle writes `in_data` into buffer row `row_cnt`, then increments `row_cnt`.
  - Accepting row N-1 moves the block to EMIT, clears `row_cnt` and sets step counter `t`=0.
- **EMIT**
  - `in_ready`=0. `in_valid` is ignored and buffer contents are frozen.
  - `out_valid`=1.
  - `out_data[j]` = `buf[t-j][j]` when 0 <= t-j <= N-1, otherwise 0.
  - Each `out_valid && out_ready` cycle increments `t`.
  - A handshake at t = 2N-2 returns the block to LOAD.
- **Outputs outside EMIT**: `out_valid`=0, `out_last`=0, `out_data`=0.
- **Timing paths**: all outputs except `in_ready` are decoded from registered state only (`t`, state, buffer). There is no combinational path from `in_*` or `out_ready` to `out_*`.
- **Counter widths**:
  - `row_cnt`: $clog2(N) bits.
  - `t`: $clog2(2N-1) bits (4 bits for N=8).
  - Neither counter wraps within a frame. Both are explicitly cleared on the state change.
- **Reset** (any time, including mid-load or mid-emit):
  - State becomes LOAD immediately (asynchronously).
  - `row_cnt`=0, `t`=0, buffer cleared to 0.
  - `out_data`=0, `out_valid`=0, `out_last`=0, `in_ready`=0 while asserted.
  - A partially loaded frame is discarded.

## Timing
- Frame length: N accept cycles plus 2N-1 emit cycles (8 + 15 = 23 cycles minimum for N=8).
- Load-to-emit latency: the cycle after the row N-1 handshake, `out_valid`=1 with the t=0 word, which is `{0…0, buf[0][0]}`.
- Emit-to-load: the cycle after the t=2N-2 handshake, `in_ready`=1. There is no overlap between frames and no idle bubble beyond that.
- Back-pressure: while `out_ready`=0, `t`, `out_data` and `out_last` hold. No step is skipped or repeated.
- Simultaneous events:
  - `in_valid` during EMIT is dropped; upstream must respect `in_ready`.
  - `rst` overrides every handshake in the same cycle.

## Structure
- Shared package `systolic_pkg`:
  - `SYS_N` = 8 default dimension.
  - `feeder_state_t` enum {LOAD, EMIT}.
  - The skew index helper, as a function `skew_bit(t, j)`.
- No sub-module is required. The buffer is an N x N flop array inside `systolic_skew_feeder`.
- A later shared `systolic_frame_counter` module may be factored out when the output drain stage is built.

## Test plan
- **All-ones frame**: load 8 rows of 0xFF, `out_ready`=1.
  - Required `out_data` sequence: 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF, 0xFE, 0xFC, 0xF8, 0xF0, 0xE0, 0xC0, 0x80.
  - `out_last` high only on 0x80.
  - `in_ready`=1 on the following cycle.
- **Identity frame**: load rows 0x01, 0x02, 0x04 … 0x80.
  - At even t=2j, `out_data` = 1<<j; at odd t, `out_data` = 0x00.
  - 15 valid words total.
- **Back-pressure**: all-ones frame with `out_ready` low for 4 cycles at t=3.
  - `out_data` holds 0x0F for those 4 cycles.
  - The full 15-word sequence is still produced, unchanged.
- **Input gating**: drive `in_valid`=1 with 0xAA throughout EMIT.
  - `in_ready` stays 0.
  - The next frame's buffer is unaffected and its first accepted row is the first row sent after `in_ready` rises.
- **Reset mid-emit**: assert `rst` at t=5 of an all-ones frame.
  - `out_valid`, `out_data` and `out_last` go to 0 without waiting for a clock edge.
  - After release, `in_ready`=1 and a fresh identity frame emits correctly.
- **Reset mid-load**: load 3 rows, then reset, then load 8 rows of 0x0F.
  - Output matches the 0x0F frame only; none of the first 3 rows leaks through.
